// File: rtl/clmul_nib_seq_if.sv
// Purpose: operand/product handshake bundle for clmul_nib_seq.
// Signals: in_valid/in_ready/a/b (operand side), out_valid/out_ready/c (product side), busy.
// Modports: master = producer/consumer side, slave = multiplier side.
interface clmul_nib_seq_if #(
    parameter int unsigned NIB = 4
);
    logic                 in_valid;
    logic                 in_ready;
    logic [4*NIB-1:0]     a;
    logic [4*NIB-1:0]     b;
    logic                 out_valid;
    logic                 out_ready;
    logic [8*NIB-2:0]     c;
    logic                 busy;

    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, c, busy
    );

    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, c, busy
    );
endinterface

// File: rtl/clmul_nib_seq.sv
// Purpose: sequential carry-less (GF(2)[x]) multiplier built from one 4x4
//          carry-less multiplier time-shared over all NIB*NIB nibble pairs.
// Ports:   clk       - rising-edge clock
//          rst       - asynchronous active-high reset
//          bus       - clmul_nib_seq_if.slave: operands a/b with in_valid/in_ready,
//                      product c with out_valid/out_ready, busy while RUN/DONE.

// 4x4 carry-less multiplier, 7-bit product.
module mult_4_poly (
    input  logic [3:0] a_i,
    input  logic [3:0] b_i,
    output logic [6:0] p_o
);
    always_comb begin
        p_o = '0;
        for (int k = 0; k < 4; k++) begin
            if (b_i[k]) begin
                p_o = p_o ^ (7'(a_i) << k);
            end
        end
    end
endmodule

module clmul_nib_seq #(
    parameter int unsigned NIB = 4
) (
    input  logic             clk,
    input  logic             rst,
    clmul_nib_seq_if.slave   bus
);
    localparam int unsigned W_OP  = 4 * NIB;
    localparam int unsigned W_C   = 8 * NIB - 1;
    localparam int unsigned IDX_W = (NIB > 1) ? $clog2(NIB) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [W_OP-1:0]    a_q, a_d;
    logic [W_OP-1:0]    b_q, b_d;
    logic [W_C-1:0]     acc_q, acc_d;
    logic [IDX_W-1:0]   i_q, i_d;
    logic [IDX_W-1:0]   j_q, j_d;

    logic [3:0]         nib_a_c;
    logic [3:0]         nib_b_c;
    logic [6:0]         prod_c;
    logic [IDX_W:0]     sum_c;
    logic [W_C-1:0]     term_c;
    logic               last_i_c;
    logic               last_j_c;

    // Current nibble pair and its partial product placed at weight 4*(i+j).
    assign nib_a_c  = 4'(a_q >> {i_q, 2'b00});
    assign nib_b_c  = 4'(b_q >> {j_q, 2'b00});
    assign sum_c    = {1'b0, i_q} + {1'b0, j_q};
    assign term_c   = W_C'(prod_c) << {sum_c, 2'b00};
    assign last_i_c = (i_q == IDX_W'(NIB - 1));
    assign last_j_c = (j_q == IDX_W'(NIB - 1));

    mult_4_poly u_mult (
        .a_i (nib_a_c),
        .b_i (nib_b_c),
        .p_o (prod_c)
    );

    // State and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            i_q     <= '0;
            j_q     <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            i_q     <= i_d;
            j_q     <= j_d;
        end
    end

    // Next-state and datapath update.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        i_d     = i_q;
        j_d     = j_q;

        case (state_q)
            S_IDLE: begin
                if (bus.in_valid) begin
                    a_d     = bus.a;
                    b_d     = bus.b;
                    acc_d   = '0;
                    i_d     = '0;
                    j_d     = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                acc_d = acc_q ^ term_c;
                // j is the inner index; the final pair moves us to DONE.
                if (last_j_c) begin
                    j_d = '0;
                    if (last_i_c) begin
                        state_d = S_DONE;
                    end else begin
                        i_d = i_q + IDX_W'(1);
                    end
                end else begin
                    j_d = j_q + IDX_W'(1);
                end
            end
            S_DONE: begin
                if (bus.out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Status outputs are pure decodes of the state register.
    assign bus.in_ready  = (state_q == S_IDLE);
    assign bus.out_valid = (state_q == S_DONE);
    assign bus.busy      = (state_q != S_IDLE);
    assign bus.c         = acc_q;
endmodule

// File: tb/tb_clmul_nib_seq.sv
// Purpose: self-checking bench for clmul_nib_seq (NIB=4): directed vectors,
//          back-pressure, mid-run reset, throughput and a random regression,
//          all compared against a transaction-level carry-less model.
module tb_clmul_nib_seq;
    localparam int unsigned NIB  = 4;
    localparam int unsigned W_OP = 4 * NIB;
    localparam int unsigned W_C  = 8 * NIB - 1;

    logic clk;
    logic rst;

    clmul_nib_seq_if #(.NIB(NIB)) bus ();

    clmul_nib_seq #(.NIB(NIB)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Software carry-less product.
    function automatic logic [W_C-1:0] clmul_ref(input logic [W_OP-1:0] x, input logic [W_OP-1:0] y);
        logic [W_C-1:0] r;
        r = '0;
        for (int k = 0; k < int'(W_OP); k++) begin
            if (y[k]) r = r ^ (W_C'(x) << k);
        end
        return r;
    endfunction

    // Transaction model: phase 0 idle, 1 computing, 2 result available.
    int             m_phase = 0;
    int             m_cnt   = 0;
    int             n_done  = 0;
    logic [W_C-1:0] exp_q[$];

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_phase = 0;
            m_cnt   = 0;
            exp_q.delete();
        end else begin
            case (m_phase)
                0: if (bus.in_valid) begin
                    exp_q.push_back(clmul_ref(bus.a, bus.b));
                    m_cnt   = NIB * NIB;
                    m_phase = 1;
                end
                1: begin
                    m_cnt--;
                    if (m_cnt == 0) m_phase = 2;
                end
                default: if (bus.out_ready) begin
                    void'(exp_q.pop_front());
                    n_done++;
                    m_phase = 0;
                end
            endcase
        end
    end

    // Per-cycle comparison of DUT outputs against the model.
    always @(negedge clk) begin
        if (!rst) begin
            chk("in_ready", 64'(bus.in_ready), 64'(m_phase == 0));
            chk("out_valid", 64'(bus.out_valid), 64'(m_phase == 2));
            chk("busy", 64'(bus.busy), 64'(m_phase != 0));
            chk("c_known", 64'($isunknown(bus.c)), 64'(0));
            if (m_phase == 2 && exp_q.size() > 0) chk("c_model", 64'(bus.c), 64'(exp_q[0]));
        end
    end

    // One operation with literal expectation, optional back-pressure hold.
    task automatic do_op(input logic [W_OP-1:0] ta, input logic [W_OP-1:0] tb_v,
                         input logic [W_C-1:0] texp, input int hold);
        int n;
        @(negedge clk);
        chk("accept_ready", 64'(bus.in_ready), 64'(1));
        bus.a = ta; bus.b = tb_v; bus.in_valid = 1'b1; bus.out_ready = 1'b0;
        @(posedge clk); #1;
        bus.in_valid = 1'b0; bus.a = W_OP'($urandom); bus.b = W_OP'($urandom);
        n = 0;
        while (!bus.out_valid && n < 100) begin
            @(posedge clk); #1; n++;
        end
        chk("latency", 64'(n), 64'(16));
        chk("c_direct", 64'(bus.c), 64'(texp));
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            bus.in_valid = 1'b1; bus.a = W_OP'($urandom); bus.b = W_OP'($urandom);
            @(posedge clk); #1;
            chk("bp_valid", 64'(bus.out_valid), 64'(1));
            chk("bp_ready", 64'(bus.in_ready), 64'(0));
            chk("bp_c", 64'(bus.c), 64'(texp));
        end
        @(negedge clk);
        bus.in_valid = 1'b0; bus.out_ready = 1'b1;
        @(posedge clk); #1;
        chk("ret_valid", 64'(bus.out_valid), 64'(0));
        chk("ret_ready", 64'(bus.in_ready), 64'(1));
        bus.out_ready = 1'b0;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int cyc;
        int start;
        rst = 1'b1;
        bus.in_valid = 1'b0; bus.out_ready = 1'b0; bus.a = '0; bus.b = '0;
        #1;
        chk("rst_in_ready", 64'(bus.in_ready), 64'(1));
        chk("rst_out_valid", 64'(bus.out_valid), 64'(0));
        chk("rst_busy", 64'(bus.busy), 64'(0));
        chk("rst_c", 64'(bus.c), 64'(0));

        chk("pin_3x3", 64'(clmul_ref(16'h0003, 16'h0003)), 64'h5);
        chk("pin_ffff", 64'(clmul_ref(16'hFFFF, 16'hFFFF)), 64'h55555555);
        chk("pin_8000", 64'(clmul_ref(16'h8000, 16'h8000)), 64'h40000000);
        chk("pin_abcd", 64'(clmul_ref(16'h0001, 16'hABCD)), 64'hABCD);
        chk("pin_mix", 64'(clmul_ref(16'h0005, 16'h0007)), 64'h1B);

        repeat (2) @(negedge clk);
        rst = 1'b0;

        do_op(16'h0003, 16'h0003, 31'h00000005, 0);
        do_op(16'hFFFF, 16'hFFFF, 31'h55555555, 0);
        do_op(16'h8000, 16'h8000, 31'h40000000, 0);
        do_op(16'h0001, 16'hABCD, 31'h0000ABCD, 0);
        do_op(16'h0005, 16'h0007, 31'h0000001B, 5);

        // Abort mid-run.
        @(negedge clk);
        bus.a = 16'h1234; bus.b = 16'h5678; bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (6) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("abort_in_ready", 64'(bus.in_ready), 64'(1));
        chk("abort_out_valid", 64'(bus.out_valid), 64'(0));
        chk("abort_busy", 64'(bus.busy), 64'(0));
        chk("abort_c", 64'(bus.c), 64'(0));
        @(negedge clk);
        rst = 1'b0;
        do_op(16'h0003, 16'h0003, 31'h00000005, 0);

        // Sustained throughput with both handshakes held high.
        @(negedge clk);
        bus.a = 16'h00F0; bus.b = 16'h0F00; bus.in_valid = 1'b1; bus.out_ready = 1'b1;
        n = 0;
        while (!bus.out_valid && n < 100) begin
            @(posedge clk); #1; n++;
        end
        n = 0;
        do begin
            @(posedge clk); #1; n++;
        end while (!bus.out_valid && n < 100);
        chk("throughput", 64'(n), 64'(18));
        @(negedge clk);
        bus.in_valid = 1'b0;
        n = 0;
        while (!bus.in_ready && n < 100) begin
            @(posedge clk); #1; n++;
        end
        chk("tp_drain", 64'(bus.in_ready), 64'(1));

        // Random regression with stalls on both sides.
        start = n_done;
        cyc = 0;
        while ((n_done - start) < 1000 && cyc < 60000) begin
            @(negedge clk);
            bus.in_valid  = ($urandom % 4) != 0;
            bus.out_ready = ($urandom % 4) != 0;
            bus.a = W_OP'($urandom);
            bus.b = W_OP'($urandom);
            cyc++;
        end
        chk("regress_count", 64'(n_done - start), 64'(1000));
        @(negedge clk);
        bus.in_valid = 1'b0; bus.out_ready = 1'b1;
        n = 0;
        while (!bus.in_ready && n < 100) begin
            @(posedge clk); #1; n++;
        end
        chk("final_idle", 64'(bus.in_ready), 64'(1));
        @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/clmul_nib_seq.md
CLMUL_NIB_SEQ -- requirements
Module: clmul_nib_seq

Interface
REQ-001 Parameter: NIB, default 4, nibbles per operand; operand width 4*NIB, product width 8*NIB-1; legal values 2..8.
REQ-002 Port: clk  input  1  system clock, all state updates on rising edge.
REQ-003 Port: rst  input  1  asynchronous, active-high reset.
REQ-004 Port: in_valid  input  1  operand pair presented.
REQ-005 Port: in_ready  output  1  block can accept operands.
REQ-006 Port: a  input  4*NIB  operand A, GF(2)[x] polynomial, bit i = coeff of x^i.
REQ-007 Port: b  input  4*NIB  operand B, same encoding.
REQ-008 Port: out_valid  output  1  product available.
REQ-009 Port: out_ready  input  1  consumer accepts product.
REQ-010 Port: c  output  8*NIB-1  carry-less product A*B over GF(2).
REQ-011 Port: busy  output  1  high in RUN or DONE.

Function
REQ-012 The block SHALL instantiate exactly one mult_4_poly (4x4 carry-less multiplier, 7-bit product) and compute the full product by time-sharing it across NIB*NIB nibble pairs.
REQ-013 The FSM SHALL have three states: IDLE, RUN, DONE.
REQ-014 in_ready SHALL equal (state==IDLE), combinationally; in_valid outside IDLE SHALL be ignored with no side effect.
REQ-015 On a rising edge with in_valid&in_ready: latch a, b; clear accumulator to 0; reset nibble indices i=0, j=0; enter RUN.
REQ-016 In RUN, each edge SHALL XOR the 7-bit product of nibble a[4i+3:4i] and nibble b[4j+3:4j], shifted left by 4*(i+j), into the accumulator.
REQ-017 Index order: j increments each RUN edge; on j=NIB-1, j wraps to 0 and i increments; the edge processing i=j=NIB-1 SHALL transition to DONE.
REQ-018 Latency: out_valid SHALL assert exactly NIB*NIB edges after the accepting edge (16 at NIB=4).
REQ-019 Accumulator width SHALL be 8*NIB-1; shifted terms SHALL never exceed bit 8*NIB-2 (max shift 8*(NIB-1) plus 6 bits).
REQ-020 In DONE, out_valid=1 and c SHALL hold the final accumulator stable until out_ready is sampled high.
REQ-021 On an edge with out_valid&out_ready, the FSM SHALL return to IDLE; in_ready rises in the following cycle (no same-cycle turnaround).
REQ-022 out_ready while not in DONE SHALL be ignored; out_valid SHALL be 0 in IDLE and RUN.
REQ-023 c SHALL be driven only from the accumulator; its value outside DONE is don't-care for consumers but SHALL not be X after reset.
REQ-024 Latched operands SHALL not change during RUN/DONE regardless of a, b input activity.
REQ-025 Sustained throughput SHALL be one product per NIB*NIB+2 cycles with in_valid and out_ready held high.

Reset
REQ-026 rst high SHALL immediately force state=IDLE, accumulator=0, latched operands=0, indices=0, regardless of clk.
REQ-027 During and after reset: in_ready=1, out_valid=0, busy=0, c=0.
REQ-028 Reset asserted mid-RUN or in DONE SHALL abort the operation; no out_valid shall be produced for that operand pair.
REQ-029 Reset release SHALL be synchronous to clk by the integrating system; the block adds no synchronizer.

Verification
REQ-030 NIB=4: a=0x0003, b=0x0003, out_ready=1 -> out_valid 16 edges after accept, c=0x00000005.
REQ-031 a=0xFFFF, b=0xFFFF -> c=0x55555555; a=0x8000, b=0x8000 -> c=0x40000000; a=0x0001, b=0xABCD -> c=0x0000ABCD.
REQ-032 Back-pressure: out_ready=0 for 5 cycles after out_valid -> c and out_valid stable, in_ready=0, new in_valid ignored; then out_ready=1 -> IDLE next edge.
REQ-033 Reset at RUN edge 7 -> immediate in_ready=1, out_valid=0, c=0; next operand pair completes correctly with full 16-cycle latency.
REQ-034 Random regression: 1000 back-to-back pairs with random in_valid/out_ready stalls -> every c matches a software carry-less reference model, in order, none dropped or duplicated.
